// File: rtl/cdiv_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cdiv_rr_scheduler
// Description : Round-robin sharing of one pipelined complex divider between
//               NUM_REQ requesters, with ID-tagged in-order result routing.
//               Optional macro CDIV_DZ_CHECK_EN enables divide-by-zero flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module cdiv_rr_scheduler #(
    parameter  int NUM_REQ = 2,
    parameter  int W       = 28,
    parameter  int DIV_LAT = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a_re,
    input  logic [NUM_REQ*W-1:0] req_a_im,
    input  logic [NUM_REQ*W-1:0] req_b_re,
    input  logic [NUM_REQ*W-1:0] req_b_im,
    output logic                 div_valid,
    output logic [W-1:0]         div_a_re,
    output logic [W-1:0]         div_a_im,
    output logic [W-1:0]         div_b_re,
    output logic [W-1:0]         div_b_im,
    input  logic [2*W-1:0]       div_res_re,
    input  logic [2*W-1:0]       div_res_im,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [2*W-1:0]       resp_re,
    output logic [2*W-1:0]       resp_im,
    output logic                 resp_dz,
    output logic                 busy
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_found;
    logic           w_hs;
    logic           w_dz;
    logic [W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;

    // Tag pipeline: stage 0 lines up with the div_* register, stage DIV_LAT
    // with the cycle in which div_res_* carries that operation's result.
    logic [DIV_LAT:0] r_tag_v;
    logic [DIV_LAT:0] r_tag_dz;
    logic [IDW-1:0]   r_tag_id [DIV_LAT+1];

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_hs      = w_found & rst_n & ~clr;
    assign req_ready = w_hs ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    assign w_a_re = req_a_re[int'(w_gnt_idx)*W +: W];
    assign w_a_im = req_a_im[int'(w_gnt_idx)*W +: W];
    assign w_b_re = req_b_re[int'(w_gnt_idx)*W +: W];
    assign w_b_im = req_b_im[int'(w_gnt_idx)*W +: W];

`ifdef CDIV_DZ_CHECK_EN
    assign w_dz = (w_b_re == '0) && (w_b_im == '0);
`else
    assign w_dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            div_a_re <= '0;
            div_a_im <= '0;
            div_b_re <= '0;
            div_b_im <= '0;
        end else begin
            if (clr) begin
                r_ptr <= '0;
            end else if (w_hs) begin
                r_ptr <= (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_hs) begin
                div_a_re <= w_a_re;
                div_a_im <= w_a_im;
                div_b_re <= w_b_re;
                div_b_im <= w_b_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_dz <= '0;
            for (int s = 0; s <= DIV_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            for (int s = DIV_LAT; s > 0; s--) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_dz[s] <= r_tag_dz[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_tag_v[0]  <= w_hs;
            r_tag_dz[0] <= w_dz;
            r_tag_id[0] <= w_gnt_idx;
            if (clr) begin
                r_tag_v <= '0;
            end
        end
    end

    assign div_valid = r_tag_v[0];
    assign busy      = |r_tag_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_re    <= '0;
            resp_im    <= '0;
            resp_dz    <= 1'b0;
        end else begin
            resp_valid <= r_tag_v[DIV_LAT] & ~clr;
            if (r_tag_v[DIV_LAT] && !clr) begin
                resp_id <= r_tag_id[DIV_LAT];
                resp_dz <= r_tag_dz[DIV_LAT];
                resp_re <= r_tag_dz[DIV_LAT] ? '0 : div_res_re;
                resp_im <= r_tag_dz[DIV_LAT] ? '0 : div_res_im;
            end
        end
    end

endmodule
`default_nettype wire
